lif_scheduler: RTL and testbench

LIF_SCHEDULER -- requirements
Module: lif_scheduler

---
 rtl/lif_pkg.sv | 16 +
 rtl/lif_core.sv | 23 ++
 rtl/lif_scheduler.sv | 149 ++++++++++++++
 tb/tb_lif_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
// Optional refractory behaviour is selected by the LIF_REFRACTORY_EN macro.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } lif_state_e;

    localparam int MEM_W          = 8;
    localparam int DEF_THRESHOLD  = 127;
    localparam int DEF_LEAK_SHIFT = 1;

endpackage

// File: rtl/lif_core.sv
// Leak / integrate / saturate / threshold datapath, shared by every neuron.
// Purely combinational; the scheduler feeds it the neuron selected this cycle.
module lif_core
    import lif_pkg::*;
#(
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic [MEM_W-1:0] cur,
    input  logic [MEM_W-1:0] mem,
    output logic [MEM_W-1:0] sum,
    output logic             fire
);

    logic [MEM_W:0] raw;

    always_comb begin
        raw  = {1'b0, cur} + ({1'b0, mem} >> LEAK_SHIFT);
        sum  = raw[MEM_W] ? {MEM_W{1'b1}} : raw[MEM_W-1:0];
        fire = (int'(sum) >= THRESHOLD);
    end

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps N_NEURONS LIF neurons through one shared lif_core, one per cycle,
// emitting a handshaked event per spike. LIF_REFRACTORY_EN adds a one-sweep refractory skip.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    localparam int IDW       = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cur_wr,
    input  logic [IDW-1:0]       cur_id,
    input  logic [MEM_W-1:0]     cur_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 spike_valid,
    output logic [IDW-1:0]       spike_id,
    input  logic                 spike_ready,
    output logic [N_NEURONS-1:0] spike_vec
);

    lif_state_e state_q, state_d;

    logic [IDW-1:0]       idx_q, idx_d;
    logic [MEM_W-1:0]     mem_q [N_NEURONS];
    logic [MEM_W-1:0]     mem_d [N_NEURONS];
    logic [MEM_W-1:0]     cur_q [N_NEURONS];
    logic [MEM_W-1:0]     cur_d [N_NEURONS];
    logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;

    logic [MEM_W-1:0] core_sum;
    logic             core_fire;
    logic             refr_now;
    logic             fire_eff;
    logic             last;

    lif_core #(
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_core (
        .cur  (cur_q[idx_q]),
        .mem  (mem_q[idx_q]),
        .sum  (core_sum),
        .fire (core_fire)
    );

`ifdef LIF_REFRACTORY_EN
    logic [N_NEURONS-1:0] refr_q, refr_d;

    assign refr_now = refr_q[idx_q];

    // The flag is rewritten on every update, so a skipped sweep clears it.
    always_comb begin
        refr_d = refr_q;
        if (state_q == ST_UPDATE) refr_d[idx_q] = fire_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) refr_q <= '0;
        else     refr_q <= refr_d;
    end
`else
    assign refr_now = 1'b0;
`endif

    assign fire_eff = core_fire && !refr_now;
    assign last     = (idx_q == IDW'(N_NEURONS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_UPDATE;
            ST_UPDATE: begin
                if (fire_eff)  state_d = ST_EMIT;
                else if (last) state_d = ST_DONE;
            end
            ST_EMIT:   if (spike_ready) state_d = last ? ST_DONE : ST_UPDATE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even before the state flops clear.
    always_comb begin
        busy        = !rst && (state_q == ST_UPDATE || state_q == ST_EMIT);
        done        = !rst && (state_q == ST_DONE);
        spike_valid = !rst && (state_q == ST_EMIT);
        spike_id    = idx_q;
        spike_vec   = spike_vec_q;
    end

    // Datapath: index walk, membrane/current storage, spike flags
    always_comb begin
        idx_d       = idx_q;
        mem_d       = mem_q;
        cur_d       = cur_q;
        spike_vec_d = spike_vec_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d       = '0;
                    spike_vec_d = '0;
                end
            end
            ST_UPDATE: begin
                if (fire_eff) begin
                    mem_d[idx_q]       = '0;
                    spike_vec_d[idx_q] = 1'b1;
                end else begin
                    mem_d[idx_q] = refr_now ? '0 : core_sum;
                    if (!last) idx_d = idx_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (spike_ready && !last) idx_d = idx_q + 1'b1;
            end
            default: idx_d = '0;
        endcase

        // The core already read the old current this cycle, so a same-cycle write is safe.
        if (cur_wr && (int'(cur_id) < N_NEURONS)) cur_d[cur_id] = cur_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            spike_vec_q <= '0;
            mem_q       <= '{default: '0};
            cur_q       <= '{default: '0};
        end else begin
            idx_q       <= idx_d;
            spike_vec_q <= spike_vec_d;
            mem_q       <= mem_d;
            cur_q       <= cur_d;
        end
    end

endmodule

// File: tb/tb_lif_scheduler.sv
// Scoreboard bench for lif_scheduler: stimulus queues expected spikes/sweep vectors,
// a negedge monitor pops and compares them. Follows LIF_REFRACTORY_EN if defined.
module tb_lif_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cur_wr;
    logic [1:0]   cur_id;
    logic [7:0]   cur_data;
    logic         start;
    logic         busy, done, spike_valid, spike_ready;
    logic [1:0]   spike_id;
    logic [N-1:0] spike_vec;

    logic         s_cur_wr;
    logic [1:0]   s_cur_id;
    logic [7:0]   s_cur_data;
    logic         s_start;
    logic         s_busy, s_done, s_spike_valid;
    logic [1:0]   s_spike_id;
    logic [N-1:0] s_spike_vec;

    int checks   = 0;
    int failures = 0;

    logic [1:0]   exp_ids  [$];
    logic [N-1:0] exp_vecs [$];

    logic       stalled_prev = 1'b0;
    logic [1:0] stalled_id   = '0;
    logic [1:0] s_last_id    = '0;
    int         s_spk_cnt    = 0;

    always #5 clk = ~clk;

    lif_scheduler #(.N_NEURONS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .cur_wr      (cur_wr),
        .cur_id      (cur_id),
        .cur_data    (cur_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .spike_valid (spike_valid),
        .spike_id    (spike_id),
        .spike_ready (spike_ready),
        .spike_vec   (spike_vec)
    );

    // Second instance with the threshold at its ceiling to expose saturation.
    lif_scheduler #(.N_NEURONS(N), .THRESHOLD(255)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .cur_wr      (s_cur_wr),
        .cur_id      (s_cur_id),
        .cur_data    (s_cur_data),
        .start       (s_start),
        .busy        (s_busy),
        .done        (s_done),
        .spike_valid (s_spike_valid),
        .spike_id    (s_spike_id),
        .spike_ready (1'b1),
        .spike_vec   (s_spike_vec)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (stalled_prev) begin
                check("stall_valid_held", {31'b0, spike_valid}, 1);
                check("stall_id_held", {30'b0, spike_id}, {30'b0, stalled_id});
            end
            stalled_prev = spike_valid && !spike_ready;
            stalled_id   = spike_id;
            if (spike_valid && spike_ready) begin
                if (exp_ids.size() == 0) check("unexpected_spike", 1, 0);
                else check("spike_id", {30'b0, spike_id}, {30'b0, exp_ids.pop_front()});
            end
            if (done) begin
                if (exp_vecs.size() == 0) check("unexpected_done", 1, 0);
                else check("spike_vec_at_done", {28'b0, spike_vec}, {28'b0, exp_vecs.pop_front()});
            end
            if (s_spike_valid) begin
                s_last_id = s_spike_id;
                s_spk_cnt++;
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_valid", {31'b0, spike_valid}, 0);
        tick();
        rst = 1'b0;
        check("rst_spike_vec", {28'b0, spike_vec}, 0);
    endtask

    task automatic write_cur(input logic [1:0] id, input logic [7:0] data);
        cur_wr = 1'b1; cur_id = id; cur_data = data;
        tick();
        cur_wr = 1'b0;
    endtask

    task automatic push_exp(input logic [N-1:0] vec);
        exp_vecs.push_back(vec);
        for (int i = 0; i < N; i++) if (vec[i]) exp_ids.push_back(2'(i));
    endtask

    task automatic finish_sweep(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) check({name, "_timeout"}, 0, 1);
        tick();
        check({name, "_idle_busy"}, {31'b0, busy}, 0);
    endtask

    task automatic sweep(input string name, input logic [N-1:0] vec);
        push_exp(vec);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_sweep(name);
    endtask

    task automatic s_write(input logic [1:0] id, input logic [7:0] data);
        s_cur_wr = 1'b1; s_cur_id = id; s_cur_data = data;
        tick();
        s_cur_wr = 1'b0;
    endtask

    task automatic s_sweep(input string name, input logic [N-1:0] vec);
        int n = 0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_done && n < 100);
        if (!s_done) check({name, "_timeout"}, 0, 1);
        check(name, {28'b0, s_spike_vec}, {28'b0, vec});
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount, dcyc, vcount, n;
        rst = 1'b1; cur_wr = 1'b0; cur_id = '0; cur_data = '0; start = 1'b0; spike_ready = 1'b1;
        s_cur_wr = 1'b0; s_cur_id = '0; s_cur_data = '0; s_start = 1'b0;
        do_reset();

        // Saturation: mem 200 -> 255 + 100 = 355 clamps to 255, meets threshold 255.
        s_write(2, 200);
        s_sweep("sat_first_sweep", 4'b0000);
        s_write(2, 255);
        s_sweep("sat_spike_sweep", 4'b0100);
        check("sat_spike_count", s_spk_cnt, 1);
        check("sat_spike_id", {30'b0, s_last_id}, 2);

        // 100 integrates to mem 100, then 100 + 50 = 150 spikes.
        write_cur(0, 100);
        sweep("integrate_no_spike", 4'b0000);
        sweep("integrate_spike", 4'b0001);
        write_cur(0, 0);
        sweep("quiet_sweep", 4'b0000);

        // Latency and mid-sweep start rejection.
        push_exp(4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        dcount = 0; dcyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin dcount++; dcyc = c; end
            if (c == 2) start = 1'b1;
            if (c == 3) start = 1'b0;
        end
        check("latency_done_count", dcount, 1);
        check("latency_done_cycle", dcyc, N + 1);
        tick();

        // Reset while neuron 1 is being updated.
        write_cur(1, 200);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_done", {31'b0, done}, 0);
        check("midrst_valid", {31'b0, spike_valid}, 0);
        tick();
        rst = 1'b0;
        dcount = 0; vcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) dcount++;
            if (spike_valid || busy) vcount++;
        end
        check("midrst_no_done", dcount, 0);
        check("midrst_idle", vcount, 0);
        check("midrst_spike_vec", {28'b0, spike_vec}, 0);
        tick();
        sweep("post_rst_cur_cleared", 4'b0000);

        // Back-pressure on neuron 3's spike.
        write_cur(3, 130);
        spike_ready = 1'b0;
        push_exp(4'b1000);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!spike_valid && n < 50);
        check("stall_seen_valid", {31'b0, spike_valid}, 1);
        for (int k = 0; k < 3; k++) begin
            check("stall_busy", {31'b0, busy}, 1);
            check("stall_id", {30'b0, spike_id}, 3);
            @(negedge clk);
        end
        tick();
        spike_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("stall_resume_done", {31'b0, done}, 1);
        tick();

        // Strong drive: refractory variant skips every other sweep.
        do_reset();
        write_cur(0, 200);
        sweep("refr_sweep1", 4'b0001);
`ifdef LIF_REFRACTORY_EN
        sweep("refr_sweep2", 4'b0000);
`else
        sweep("refr_sweep2", 4'b0001);
`endif
        sweep("refr_sweep3", 4'b0001);

        // Current rewritten while its neuron is in the update slot.
        do_reset();
        write_cur(1, 100);
        push_exp(4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cur_wr = 1'b1; cur_id = 2'd1; cur_data = 8'd200;
        tick();
        cur_wr = 1'b0;
        finish_sweep("collide_old_current");
        sweep("collide_new_current", 4'b0010);

        repeat (3) tick();
        check("scoreboard_drained", exp_ids.size() + exp_vecs.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
